// File: rtl/perf_counter_bank_if.sv
// Status/readout bundle between the pipeline-side observer and perf_counter_bank.
// PERF_OVF_IRQ_EN adds the irq line.
interface perf_counter_bank_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned OP_W  = 4
);
  logic             start;
  logic             clear;
  logic [OP_W-1:0]  Op;
  logic             stall;
  logic             kill;
  logic             done;
  logic [2:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic [7:0]       ovf;
  logic [1:0]       state;
`ifdef PERF_OVF_IRQ_EN
  logic             irq;
`endif

  modport master (
    output start, clear, Op, stall, kill, done, rd_sel,
`ifdef PERF_OVF_IRQ_EN
    input  irq,
`endif
    input  rd_data, ovf, state
  );

  modport slave (
    input  start, clear, Op, stall, kill, done, rd_sel,
`ifdef PERF_OVF_IRQ_EN
    output irq,
`endif
    output rd_data, ovf, state
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Eight pipeline performance counters with start/freeze/clear control, sticky overflow
// flags and a registered readout port. Optional macro PERF_OVF_IRQ_EN adds a sticky irq output.
module perf_counter_bank #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned OP_W     = 4
) (
  input logic CLK,
  input logic RST,
  perf_counter_bank_if.slave bus
);

  localparam int unsigned NUM_CNT = 8;

  localparam int unsigned IDX_EX    = 0;
  localparam int unsigned IDX_LW    = 1;
  localparam int unsigned IDX_SW    = 2;
  localparam int unsigned IDX_ALU   = 3;
  localparam int unsigned IDX_CTRL  = 4;
  localparam int unsigned IDX_CLK   = 5;
  localparam int unsigned IDX_STALL = 6;
  localparam int unsigned IDX_KILL  = 7;

  // Opcode encodings shared with the pipeline decoder.
  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_FOR  = OP_W'(8);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FROZEN = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q [NUM_CNT];
  logic [CNT_W-1:0]      cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0]    ovf_q, ovf_d;
  logic [CNT_W-1:0]      rd_data_q, rd_data_d;
  logic [NUM_CNT-1:0]    inc;
  logic                  is_alu, is_lw, is_sw, is_ctrl;
  logic                  done_rise;

  assign done_rise = bus.done & ~done_q;

  // Instruction class decode; unrecognised opcodes set no class bit.
  always_comb begin
    is_alu  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_ctrl = 1'b0;
    case (bus.Op)
      OP_R, OP_ANDI, OP_ADDI: is_alu = 1'b1;
      OP_LW:                  begin is_lw = 1'b1; is_alu = 1'b1; end
      OP_SW:                  begin is_sw = 1'b1; is_alu = 1'b1; end
      OP_BEQ, OP_BNE, OP_J:   is_ctrl = 1'b1;
      OP_FOR:                 begin is_alu = 1'b1; is_ctrl = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    done_d    = bus.done;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    rd_data_d = cnt_q[bus.rd_sel];
    inc       = '0;

    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_RUN;
      ST_RUN:    if (done_rise) state_d = ST_FROZEN;
      ST_FROZEN: state_d = ST_FROZEN;
      default:   state_d = ST_IDLE;
    endcase

    if (state_q == ST_RUN) begin
      inc[IDX_CLK]   = 1'b1;
      inc[IDX_STALL] = bus.stall | bus.kill;
      inc[IDX_KILL]  = bus.kill;
      inc[IDX_EX]    = ~bus.stall & (is_alu | is_ctrl);
      inc[IDX_LW]    = ~bus.stall & is_lw;
      inc[IDX_SW]    = ~bus.stall & is_sw;
      inc[IDX_ALU]   = ~bus.stall & is_alu;
      inc[IDX_CTRL]  = ~bus.stall & is_ctrl;
    end

    // Increment from all-ones flags overflow and either wraps or sticks.
    for (int i = 0; i < NUM_CNT; i++) begin
      if (inc[i]) begin
        if (cnt_q[i] == '1) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    if (bus.clear) begin
      state_d = ST_IDLE;
      ovf_d   = '0;
      for (int i = 0; i < NUM_CNT; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      ovf_q     <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.ovf     = ovf_q;
  assign bus.state   = state_q;

`ifdef PERF_OVF_IRQ_EN
  logic irq_q, irq_d;

  // Rises together with the first new overflow flag and stays up until clear.
  always_comb begin
    irq_d = irq_q | (|(ovf_d & ~ovf_q));
    if (bus.clear) irq_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised bank of eight pipeline performance counters: executed, load, store, ALU, control, clock, stall and killed.
- Sits beside the pipeline and samples the Op, stall, kill and done status each cycle.
- Adds width and wrap/saturate parametrisation, a start/freeze/clear state machine, sticky overflow flags and a registered readout port.

Parameters:
- CNT_W, 32: width of each counter and of rd_data (legal range 8..64).
- SATURATE, 0: 0 = counters wrap to 0 on overflow; 1 = counters hold at all-ones.
- OP_W, 4: width of the Op input; opcode values come from the shared opcode definitions file.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  level; IDLE->RUN.
- clear  in  1  synchronous clear of all counters, overflow flags and state.
- Op  in  OP_W  opcode of the instruction retiring this cycle.
- stall  in  1  pipeline stalled this cycle.
- kill  in  1  instruction killed this cycle.
- done  in  1  program finished; its rising edge freezes the bank.
- rd_sel  in  3  counter index: 0 ex, 1 lw, 2 sw, 3 alu, 4 ctrl, 5 clk, 6 stall, 7 kill.
- rd_data  out  CNT_W  registered value of the selected counter.
- ovf  out  8  sticky overflow flags, bit i for counter i.
- state  out  2  00 IDLE, 01 RUN, 10 FROZEN.

Behaviour:
- Reset (RST high, asynchronous): all counters 0, ovf 0, rd_data 0, state IDLE, done-edge register 0.
- FSM transitions:
  - IDLE -> RUN when start=1. No counting happens in the cycle start is sampled.
  - RUN -> FROZEN on a done rising edge (done=1 and registered done_q=0). Events in the edge cycle are still counted.
  - FROZEN holds until clear; start is ignored in FROZEN.
  - Any state -> IDLE on clear.
  - done held high does not re-trigger.
- Counting happens only in RUN, once per cycle:
  - clk: +1 every cycle.
  - stall: +1 if stall|kill.
  - kill: +1 if kill.
  - When stall=0, Op is classified:
    - R-type 4'b0000, ANDI, ADDI: alu.
    - LW: lw and alu.
    - SW: sw and alu.
    - BEQ, BNE, J-type 4'b0001: ctrl.
    - FOR: alu and ctrl.
    - Any other value: unrecognised.
  - ex: +1 if stall=0 and Op is recognised.
  - When stall=1, no class counter and no ex update.
- Overflow: an increment from all-ones sets ovf[i] (sticky until clear/RST).
  - SATURATE=0: counter becomes 0.
  - SATURATE=1: counter stays all-ones.
- clear has priority over counting in the same cycle: all counters 0, ovf 0, state IDLE.
- Readout latency is 1 cycle: rd_data <= counter[rd_sel] as it stands before this edge's increment. Readout works in every state.
- RST asserted mid-RUN: immediate return to reset values; no partial updates.
- All arithmetic is unsigned CNT_W bits; no carry out beyond the ovf flag.

Optional Feature:
- Macro: PERF_OVF_IRQ_EN.
- Defined: extra output port irq (1 bit), registered.
  - irq goes high the cycle after any ovf bit transitions 0->1.
  - irq stays high until clear or RST.
- Undefined: no irq port and no associated logic. ovf still exists.

Test Plan:
- Reset then start, 10 cycles of Op=ADDI with stall=0, then done rising -> read all counters:
  - ex=10, alu=10, clk=10, others 0.
  - state=FROZEN.
  - A further 5 cycles of ADDI leave every value unchanged.
- RUN with LW, SW, FOR, BEQ, 4'b0001 one cycle each -> lw=1, sw=1, alu=3, ctrl=3, ex=5, clk=5.
- RUN 4 cycles with stall=1 and Op=LW, then 2 cycles with kill=1 and Op=ADDI -> stall=6, kill=2, lw=0, alu=2, ex=2.
- CNT_W=8, SATURATE=0, 257 RUN cycles -> clk=1, ovf[5]=1. With PERF_OVF_IRQ_EN, irq high from the cycle after the wrap.
- Same stimulus with SATURATE=1 -> clk=255, ovf[5]=1.
- Mid-RUN with counters nonzero:
  - clear together with Op=ADDI -> all counters 0, state IDLE, ADDI not counted.
  - RST pulse mid-RUN -> outputs 0 asynchronously, before the next CLK edge.
